// File: rtl/an_sec_decode_ctrl.sv
// rtl/an_sec_decode_ctrl.sv - sequential single-error-correcting AN-code (A=655) decoder controller
// Two bit-serial restoring-division passes around a combinational remainder-to-location lookup.

module an_sec_rlut (
  input  logic [9:0]        i_r,
  output logic signed [4:0] o_loc
);
  // Remainder of +/-2^(k-1) mod 655 maps to location +/-k; all 28 syndromes are distinct.
  always_comb begin
    o_loc = 5'sd0;
    case (i_r)
      10'd1:   o_loc = 5'sd1;
      10'd2:   o_loc = 5'sd2;
      10'd4:   o_loc = 5'sd3;
      10'd8:   o_loc = 5'sd4;
      10'd16:  o_loc = 5'sd5;
      10'd32:  o_loc = 5'sd6;
      10'd64:  o_loc = 5'sd7;
      10'd128: o_loc = 5'sd8;
      10'd256: o_loc = 5'sd9;
      10'd512: o_loc = 5'sd10;
      10'd369: o_loc = 5'sd11;
      10'd83:  o_loc = 5'sd12;
      10'd166: o_loc = 5'sd13;
      10'd332: o_loc = 5'sd14;
      10'd654: o_loc = -5'sd1;
      10'd653: o_loc = -5'sd2;
      10'd651: o_loc = -5'sd3;
      10'd647: o_loc = -5'sd4;
      10'd639: o_loc = -5'sd5;
      10'd623: o_loc = -5'sd6;
      10'd591: o_loc = -5'sd7;
      10'd527: o_loc = -5'sd8;
      10'd399: o_loc = -5'sd9;
      10'd143: o_loc = -5'sd10;
      10'd286: o_loc = -5'sd11;
      10'd572: o_loc = -5'sd12;
      10'd489: o_loc = -5'sd13;
      10'd323: o_loc = -5'sd14;
      default: o_loc = 5'sd0;
    endcase
  end
endmodule

module an_sec_decode_ctrl #(
  parameter int A     = 655,
  parameter int CW    = 14,
  parameter int DW    = 4,
  parameter int RW    = 10,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [CW-1:0]        out_code,
  output logic signed [4:0]    out_loc,
  output logic                 out_corr,
  output logic                 out_fail,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     fail_cnt
);
  localparam int            CB  = $clog2(CW);
  localparam logic [RW:0]   C_A = A[RW:0];

  typedef enum logic [2:0] {S_IDLE, S_DIV1, S_LUT, S_CORR, S_DIV2, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_y;
  logic [CW-1:0]      r_x;
  logic [CW-1:0]      r_sh;
  logic [RW-1:0]      r_rem;
  logic [CB-1:0]      r_cnt;
  logic signed [4:0]  r_loc;
  logic               r_fail;

  logic [RW:0]        w_p;
  logic               w_ge;
  logic [RW:0]        w_pm;
  logic signed [4:0]  w_lut_loc;
  logic [4:0]         w_mag;
  logic [CW:0]        w_pow;
  logic [CW:0]        w_x15;
  logic [CW-1:0]      w_q;
  logic               w_fail2;
  logic               w_hs;

  an_sec_rlut u_rlut (
    .i_r   (r_rem),
    .o_loc (w_lut_loc)
  );

  // One restoring-division step shared by both passes: dividend bits leave the MSB
  // of r_sh while quotient bits enter at the LSB.
  assign w_p  = {r_rem, r_sh[CW-1]};
  assign w_ge = (w_p >= C_A);
  assign w_pm = w_ge ? (w_p - C_A) : w_p;
  assign w_q  = {r_sh[CW-2:0], w_ge};

  assign w_mag   = r_loc[4] ? (~r_loc + 5'd1) : r_loc;
  assign w_pow   = (w_mag == 5'd0) ? '0 : ({{CW{1'b0}}, 1'b1} << (w_mag - 5'd1));
  assign w_x15   = (r_loc > 5'sd0) ? ({1'b0, r_y} - w_pow) :
                   (r_loc < 5'sd0) ? ({1'b0, r_y} + w_pow) : {1'b0, r_y};

  assign w_fail2 = r_fail | (w_pm[RW-1:0] != '0) | (w_q[CW-1:DW] != '0);
  assign w_hs    = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_y       <= '0;
      r_x       <= '0;
      r_sh      <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_loc     <= 5'sd0;
      r_fail    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_code  <= '0;
      out_loc   <= 5'sd0;
      out_corr  <= 1'b0;
      out_fail  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_y      <= in_code;
            r_sh     <= in_code;
            r_rem    <= '0;
            r_cnt    <= CB'(CW - 1);
            r_fail   <= 1'b0;
            in_ready <= 1'b0;
            r_state  <= S_DIV1;
          end
        end
        S_DIV1: begin
          r_sh  <= w_q;
          r_rem <= w_pm[RW-1:0];
          r_cnt <= r_cnt - CB'(1);
          if (r_cnt == '0) r_state <= S_LUT;
        end
        S_LUT: begin
          r_loc   <= w_lut_loc;
          r_state <= S_CORR;
        end
        S_CORR: begin
          // A location that pushes X outside 14 bits means the error was not single.
          r_x     <= w_x15[CW-1:0];
          r_sh    <= w_x15[CW-1:0];
          r_fail  <= ((r_rem != '0) && (r_loc == 5'sd0)) || w_x15[CW];
          r_rem   <= '0;
          r_cnt   <= CB'(CW - 1);
          r_state <= S_DIV2;
        end
        S_DIV2: begin
          r_sh  <= w_q;
          r_rem <= w_pm[RW-1:0];
          r_cnt <= r_cnt - CB'(1);
          if (r_cnt == '0) begin
            out_valid <= 1'b1;
            out_fail  <= w_fail2;
            out_corr  <= (r_loc != 5'sd0) && !w_fail2;
            out_data  <= w_fail2 ? '0 : w_q[DW-1:0];
            out_code  <= w_fail2 ? r_y : r_x;
            out_loc   <= w_fail2 ? 5'sd0 : r_loc;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Clear has priority over a same-cycle handshake increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
      fail_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt <= '0;
      fail_cnt <= '0;
    end else if (w_hs) begin
      if (out_corr && (corr_cnt != '1)) corr_cnt <= corr_cnt + CNT_W'(1);
      if (out_fail && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_an_sec_decode_ctrl.sv
// tb/tb_an_sec_decode_ctrl.sv - directed plus randomized bench for an_sec_decode_ctrl
module tb_an_sec_decode_ctrl;
  localparam int TB_CNT_W = 2;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [13:0]          in_code;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_data;
  logic [13:0]          out_code;
  logic signed [4:0]    out_loc;
  logic                 out_corr;
  logic                 out_fail;
  logic                 cnt_clr;
  logic [TB_CNT_W-1:0]  corr_cnt;
  logic [TB_CNT_W-1:0]  fail_cnt;

  int total = 0;
  int bad   = 0;
  int m_corr = 0;
  int m_fail = 0;

  an_sec_decode_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_code  (out_code),
    .out_loc   (out_loc),
    .out_corr  (out_corr),
    .out_fail  (out_fail),
    .cnt_clr   (cnt_clr),
    .corr_cnt  (corr_cnt),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference decoder: residue search over all single +/-2^i errors, then integer division.
  function automatic void model(input int y, output int loc, output int code,
                                output int data, output int corr, output int fail);
    int r, l, x, p;
    r = y % 655;
    l = 0;
    for (int i = 0; i < 14; i++) begin
      p = (1 << i) % 655;
      if (p == r) l = i + 1;
      if (((655 - p) % 655) == r) l = -(i + 1);
    end
    if (l > 0)      x = y - (1 << (l - 1));
    else if (l < 0) x = y + (1 << (-l - 1));
    else            x = y;
    fail = 0;
    if (r != 0 && l == 0) fail = 1;
    if (x < 0 || x >= 16384) fail = 1;
    else if ((x % 655) != 0 || (x / 655) > 15) fail = 1;
    if (fail != 0) begin
      loc = 0; code = y; data = 0; corr = 0;
    end else begin
      loc = l; code = x; data = x / 655; corr = (l != 0) ? 1 : 0;
    end
  endfunction

  task automatic run_word(input int y, input int hold, input bit clr);
    int e_loc, e_code, e_data, e_corr, e_fail;
    model(y, e_loc, e_code, e_data, e_corr, e_fail);
    @(negedge clk);
    in_valid  = 1'b1;
    in_code   = 14'(y);
    out_ready = (hold == 0);
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_code = 14'($urandom);
    chk("in_ready_busy", in_ready, 0);
    repeat (29) @(posedge clk);
    @(negedge clk);
    chk("valid_before_e30", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("valid_after_e30", out_valid, 1);
    chk("out_data", out_data, e_data);
    chk("out_code", out_code, e_code);
    chk("out_loc", out_loc, e_loc);
    chk("out_corr", out_corr, e_corr);
    chk("out_fail", out_fail, e_fail);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_code", out_code, e_code);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    cnt_clr   = clr;
    @(posedge clk);
    if (clr) begin
      m_corr = 0;
      m_fail = 0;
    end else begin
      if (e_corr != 0 && m_corr < CNT_MAX) m_corr++;
      if (e_fail != 0 && m_fail < CNT_MAX) m_fail++;
    end
    @(negedge clk);
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    chk("valid_after_hs", out_valid, 0);
    chk("in_ready_after_hs", in_ready, 1);
    chk("corr_cnt", corr_cnt, m_corr);
    chk("fail_cnt", fail_cnt, m_fail);
  endtask

  initial begin
    int d, y, kind, hold;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_code", out_code, 0);
    chk("rst_corr_cnt", corr_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    rst_n = 1'b1;

    run_word(5895, 0, 1'b0);
    run_word(5903, 0, 1'b0);
    run_word(9824, 0, 1'b0);
    run_word(3, 0, 1'b0);
    run_word(655 * 6 + 64, 20, 1'b0);

    @(negedge clk);
    in_valid = 1'b1;
    in_code  = 14'(655 * 3 ^ 16);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_corr = 0;
    m_fail = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_loc", out_loc, 0);
    chk("midrst_corr_cnt", corr_cnt, 0);
    chk("midrst_fail_cnt", fail_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      run_word((655 * (i + 2)) ^ (1 << (i * 3)), 0, 1'b0);
    run_word(655 * 11 ^ (1 << 13), 0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      d    = $urandom_range(0, 15);
      kind = $urandom_range(0, 3);
      case (kind)
        0:       y = 655 * d;
        1, 2:    y = (655 * d) ^ (1 << $urandom_range(0, 13));
        default: y = $urandom_range(0, 16383);
      endcase
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_word(y, hold, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/an_sec_decode_ctrl.md
Name: an_sec_decode_ctrl

Overview:
- Sequential single-error-correcting decoder controller for the 4-bit-data product (AN) code, A = 655, 14-bit codewords.
- Pass 1: reduces the received word mod 655 by bit-serial restoring division. The remainder drives the existing SEC r-LUT (instantiated, combinational) to get the signed error location.
- The block then corrects the word. Pass 2 divides the corrected codeword by 655 to recover the data.
- Sits between the codeword receive buffer and the data consumer; valid/ready on both sides; keeps saturating correction and failure statistics.

Parameters:
- A, 655, code multiplier. Only 655 is supported; the LUT is hard-wired to it.
- CW, 14, codeword width.
- DW, 4, data width.
- RW, 10, remainder width (LUT input).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  codeword offered.
- in_ready  out  1  block can accept; high only in IDLE.
- in_code  in  CW  received codeword Y.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  DW  decoded data N = X/655.
- out_code  out  CW  corrected codeword X.
- out_loc  out  5 (signed)  LUT error location; 0 means no error or uncorrectable.
- out_corr  out  1  single error found and corrected.
- out_fail  out  1  uncorrectable.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  number of corrected words, saturating.
- fail_cnt  out  CNT_W  number of failed words, saturating.

Behaviour:
- Reset, applicable at any time including mid-operation:
  - state returns to IDLE; in_ready=1 after reset.
  - out_valid=0, all result outputs 0, both counters 0.
  - any word in flight is dropped.
- States: IDLE, DIV1, LUT, CORR, DIV2, DONE.
- IDLE:
  - in_valid & in_ready captures in_code into Y; move to DIV1.
  - Bit counter set to CW-1; partial remainder cleared.
- Division step (DIV1 and DIV2), one bit per cycle, MSB first:
  - p = {rem, next bit}, 11 bits.
  - If p >= 655: rem = p-655 and quotient bit = 1. Otherwise rem = p and quotient bit = 0.
  - CW cycles per pass.
- DIV1 -> LUT after 14 steps; r = rem[9:0].
- LUT: register l = LUT(r); one cycle; go to CORR.
- CORR, one cycle:
  - l > 0: X = Y - 2^(l-1).
  - l < 0: X = Y + 2^(|l|-1).
  - l = 0: X = Y.
  - Arithmetic is 15-bit.
  - fail if r != 0 and l == 0.
  - fail if X < 0 or X >= 2^14 (borrow or overflow from a multi-bit error).
- DIV2: divide X by 655, 14 steps.
  - fail if final remainder != 0.
  - fail if quotient > 15, i.e. any quotient bit above DW-1 set.
- DONE: out_valid=1 and all result outputs stable.
  - out_corr = (l != 0) & !fail.
  - On fail: out_data=0, out_code=Y, out_loc=0.
  - out_valid & out_ready returns to IDLE the following cycle.
  - out_valid is held indefinitely under backpressure.
- Latency is fixed whatever the error status; DIV2 always runs.
  - Accepting edge E0; DIV1 steps on E1..E14; LUT on E15; CORR on E16; DIV2 on E17..E30.
  - out_valid is high after E30.
  - Throughput: at most one word per 32 cycles with out_ready tied high; no overlap between words.
- Counters:
  - Increment on the DONE handshake: corr_cnt when out_corr, fail_cnt when out_fail.
  - Saturate at 2^CNT_W-1.
  - If cnt_clr coincides with an increment, cnt_clr wins.
- in_ready=0 in all states except IDLE; in_code is ignored outside IDLE.

Test Plan:
- Clean word: in_code=655*9=5895 -> after 30 cycles out_valid=1, out_data=9, out_code=5895, out_loc=0, out_corr=0, out_fail=0.
- Positive error: in_code=5895^0x0008 (bit3 0->1, Y=5903) -> r=8, out_loc=+4, out_code=5895, out_data=9, out_corr=1, corr_cnt=1.
- Negative error: codeword 655*15=9825 with bit0 cleared (Y=9824) -> r=654, out_loc=-1, out_code=9825, out_data=15, out_corr=1.
- Uncorrectable: in_code=3 (r=3, not in LUT) -> out_fail=1, out_loc=0, out_data=0, out_code=3, fail_cnt increments.
- Backpressure plus reset: hold out_ready=0 for 20 cycles -> out_valid and outputs stable, in_ready=0; then assert rst_n=0 mid-DIV2 on the next word -> immediate IDLE, out_valid=0, counters 0.
- Saturation and clear (CNT_W overridden to 2): four corrected words -> corr_cnt stays at 3; cnt_clr asserted together with a handshake -> corr_cnt=0.
